// File: rtl/io_input_conditioner.sv
// Board-input front end: synchronises and debounces slide switches and active-low keys,
// packs them into the core's 32-bit I/O word and emits per-channel change pulses.
module io_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned N_SW            = 10,
  parameter int unsigned N_KEY           = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_SW-1:0]  i_sw,
  input  logic [N_KEY-1:0] i_key_n,
  output logic [31:0]      o_io_sw,
  output logic [N_KEY-1:0] o_key_press,
  output logic [N_KEY-1:0] o_key_release,
  output logic [N_SW-1:0]  o_sw_change
);

  localparam int unsigned N  = N_SW + N_KEY;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]  raw;
  logic [N-1:0]  s1_q, s2_q;
  logic [N-1:0]  st_q, st_d;
  logic [N-1:0]  rise_q, rise_d;
  logic [N-1:0]  fall_q, fall_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  // Keys inverted ahead of the synchroniser so every channel is active-high.
  assign raw = {~i_key_n, i_sw};

  always_comb begin
    st_d   = st_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != st_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          st_d[i]   = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      st_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      st_q   <= st_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    o_io_sw        = '0;
    o_io_sw[N-1:0] = st_q;
  end

  assign o_key_press   = rise_q[N-1:N_SW];
  assign o_key_release = fall_q[N-1:N_SW];
  assign o_sw_change   = rise_q[N_SW-1:0] | fall_q[N_SW-1:0];

endmodule

// File: tb/tb_io_input_conditioner.sv
// Testbench for io_input_conditioner: directed scenarios plus randomized toggling,
// checked against a sliding-window reference model of the debouncer.
module tb_io_input_conditioner;
  localparam int D   = 4;
  localparam int NSW = 10;
  localparam int NK  = 4;
  localparam int N   = NSW + NK;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NSW-1:0] sw;
  logic [NK-1:0]  key_n;
  logic [31:0]    o_io_sw;
  logic [NK-1:0]  o_key_press, o_key_release;
  logic [NSW-1:0] o_sw_change;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  io_input_conditioner #(.DEBOUNCE_CYCLES(D), .N_SW(NSW), .N_KEY(NK)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_sw(sw), .i_key_n(key_n),
    .o_io_sw(o_io_sw), .o_key_press(o_key_press),
    .o_key_release(o_key_release), .o_sw_change(o_sw_change)
  );

  // Reference model: a channel flips once the last D synchronised samples all disagree
  // with its accepted value; synchronised sample = raw level from two edges earlier.
  logic [N-1:0] exp_st = '0, exp_rise = '0, exp_fall = '0;
  logic [N-1:0] smp [$];
  logic [N-1:0] s2q [$];
  logic [N-1:0] m_s2v, m_acc;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (rst_n !== 1'b1) begin
      exp_st = '0; exp_rise = '0; exp_fall = '0;
      smp.delete(); s2q.delete();
    end else begin
      m_s2v = (smp.size() >= 2) ? smp[smp.size()-2] : '0;
      smp.push_back({~key_n, sw});
      if (smp.size() > 2) void'(smp.pop_front());
      s2q.push_back(m_s2v);
      if (s2q.size() > D) void'(s2q.pop_front());
      m_acc = '0;
      if (s2q.size() == D) begin
        m_acc = '1;
        foreach (s2q[j]) m_acc = m_acc & (s2q[j] ^ exp_st);
      end
      exp_rise = m_acc & ~exp_st;
      exp_fall = m_acc & exp_st;
      exp_st   = exp_st ^ m_acc;
    end
  end

  logic [49:0] got_vec, exp_vec;
  assign got_vec = {o_io_sw, o_key_press, o_key_release, o_sw_change};
  assign exp_vec = {18'b0, exp_st, exp_rise[N-1:NSW], exp_fall[N-1:NSW],
                    exp_rise[NSW-1:0] | exp_fall[NSW-1:0]};

  task automatic test_reset();
    rst_n = 1'b0; sw = '0; key_n = '1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (got_vec !== 50'b0) $display("FAIL reset_state got=%h exp=0", got_vec);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total_cnt++;
      if (got_vec !== 50'b0) $display("FAIL idle cyc%0d got=%h exp=0", i, got_vec);
      else pass_cnt++;
    end
    // Drive everything on, then hit reset in the middle of the pulse cycle.
    sw = '1; key_n = '0;
    repeat (6) @(posedge clk);
    #1;
    total_cnt++;
    if ({o_io_sw, o_key_press, o_sw_change} !== {32'h3FFF, 4'hF, 10'h3FF})
      $display("FAIL prereset_pulse got=%h exp=%h", {o_io_sw, o_key_press, o_sw_change},
               {32'h3FFF, 4'hF, 10'h3FF});
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (got_vec !== 50'b0) $display("FAIL async_reset got=%h exp=0", got_vec);
    else pass_cnt++;
    sw = '0; key_n = '1;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_sw_latency();
    @(negedge clk) sw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({o_io_sw[0], o_sw_change[0]} !== {(k >= 6) ? 1'b1 : 1'b0, (k == 6) ? 1'b1 : 1'b0})
        $display("FAIL sw_latency k=%0d got=%b%b exp=%b%b", k, o_io_sw[0], o_sw_change[0],
                 k >= 6, k == 6);
      else pass_cnt++;
      total_cnt++;
      if (got_vec !== exp_vec) $display("FAIL sw_latency_model k=%0d got=%h exp=%h", k, got_vec, exp_vec);
      else pass_cnt++;
    end
  endtask

  task automatic test_key_bounce();
    logic [4:0] pat;
    int presses, releases;
    pat = 5'b10010;  // sequence 0,1,0,0,1 applied LSB first
    presses = 0; releases = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if (o_io_sw[10] !== 1'b0) $display("FAIL bounce_early i=%0d got=%b exp=0", i, o_io_sw[10]);
      else pass_cnt++;
      key_n[0] = pat[i];
    end
    @(negedge clk) key_n[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (o_key_press[0]) presses++;
      if (o_key_release[0]) releases++;
      total_cnt++;
      if (o_io_sw[10] !== ((k >= 6) ? 1'b1 : 1'b0))
        $display("FAIL key_bounce k=%0d got=%b exp=%b", k, o_io_sw[10], k >= 6);
      else pass_cnt++;
      total_cnt++;
      if (got_vec !== exp_vec) $display("FAIL key_bounce_model k=%0d got=%h exp=%h", k, got_vec, exp_vec);
      else pass_cnt++;
    end
    total_cnt++;
    if (presses != 1 || releases != 0)
      $display("FAIL key_press_count got=%0d/%0d exp=1/0", presses, releases);
    else pass_cnt++;
  endtask

  task automatic test_key_release_glitch();
    int rels, presses;
    rels = 0; presses = 0;
    @(negedge clk) key_n[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (o_key_release[0]) rels++;
      total_cnt++;
      if (o_io_sw[10] !== ((k < 6) ? 1'b1 : 1'b0))
        $display("FAIL key_release k=%0d got=%b exp=%b", k, o_io_sw[10], k < 6);
      else pass_cnt++;
    end
    total_cnt++;
    if (rels != 1) $display("FAIL release_count got=%0d exp=1", rels);
    else pass_cnt++;
    @(negedge clk) key_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    key_n[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_key_press[0]) presses++;
      total_cnt++;
      if (o_io_sw[10] !== 1'b0 || got_vec !== exp_vec)
        $display("FAIL glitch k=%0d got=%h exp=%h", k, got_vec, exp_vec);
      else pass_cnt++;
    end
    total_cnt++;
    if (presses != 0) $display("FAIL glitch_press_count got=%0d exp=0", presses);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b0; sw = '0; key_n = '1;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) begin sw = '1; key_n = '0; end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (k == 6) begin
        if ({o_io_sw, o_sw_change, o_key_press} !== {32'h0000_3FFF, 10'h3FF, 4'hF})
          $display("FAIL simultaneous got=%h/%h/%h exp=00003fff/3ff/f", o_io_sw, o_sw_change, o_key_press);
        else pass_cnt++;
      end else begin
        if (o_io_sw !== ((k > 6) ? 32'h3FFF : 32'h0) || o_sw_change !== '0 || o_key_press !== '0)
          $display("FAIL simultaneous_k%0d got=%h exp=%h", k, o_io_sw, (k > 6) ? 32'h3FFF : 32'h0);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_midcount();
    rst_n = 1'b0; sw = '0; key_n = '1;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) sw = 10'h020;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (got_vec !== 50'b0) $display("FAIL midcount_reset got=%h exp=0", got_vec);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({o_io_sw[5], o_sw_change[5]} !== {(k >= 6) ? 1'b1 : 1'b0, (k == 6) ? 1'b1 : 1'b0})
        $display("FAIL midcount_restart k=%0d got=%b%b exp=%b%b", k, o_io_sw[5], o_sw_change[5],
                 k >= 6, k == 6);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    rst_n = 1'b0; sw = '0; key_n = '1;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      total_cnt++;
      if (got_vec !== exp_vec) $display("FAIL random c=%0d got=%h exp=%h", c, got_vec, exp_vec);
      else pass_cnt++;
      if (c == 400) begin
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (got_vec !== 50'b0) $display("FAIL random_reset got=%h exp=0", got_vec);
        else pass_cnt++;
        #1 rst_n = 1'b1;
      end
      if (hold == 0) begin
        sw    = sw ^ NSW'($urandom & $urandom);
        key_n = key_n ^ NK'($urandom & $urandom);
        hold  = int'($urandom_range(1, 8));
      end else begin
        hold--;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sw = '0; key_n = '1;
    test_reset();
    test_sw_latency();
    test_key_bounce();
    test_key_release_glitch();
    test_simultaneous();
    test_reset_midcount();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Board-input front end placed directly upstream of the pipelined core's `i_io_sw` port on the DE10-Standard build. It synchronises the raw slide switches and active-low push buttons into the core clock domain and debounces each line independently. It inverts the keys to active-high and packs the result into the 32-bit word the core reads. It also produces one-cycle press/release/change pulses for board-level logic such as the LED "event" indicators.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before a line is accepted; 10 ms at 25 MHz; legal range ≥1.
- `N_SW`, default 10: number of slide switches.
- `N_KEY`, default 4: number of push buttons. The constraint `N_SW + N_KEY ≤ 32` holds.

Ports:
- `i_clk`  in  1  core clock (divided board clock).
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_sw`  in  N_SW  raw switches, asynchronous; ON=1.
- `i_key_n`  in  N_KEY  raw buttons, asynchronous, active-low (pressed=0).
- `o_io_sw`  out  32  packed word: `{zeros, key_pressed[N_KEY-1:0], sw_stable[N_SW-1:0]}`; feeds the core `i_io_sw`.
- `o_key_press`  out  N_KEY  one-cycle pulse per key on debounced press.
- `o_key_release`  out  N_KEY  one-cycle pulse per key on debounced release.
- `o_sw_change`  out  N_SW  one-cycle pulse per switch on any debounced change.

## Operation
- There are N_SW+N_KEY identical channels. Each channel has a 2-flop synchroniser (`s1`→`s2`), a stable register `st`, and a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`.
- Key channels are inverted before the synchroniser, so every channel works in active-high "asserted" sense.
- Each cycle, per channel:
  - If `s2 == st`: `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`: `st <= s2`, `cnt <= 0`, and the channel event pulse is raised next cycle.
  - Else: `cnt <= cnt + 1`.
- Bounce rule: any single cycle with `s2 == st` during counting clears `cnt`. Acceptance needs DEBOUNCE_CYCLES *consecutive* mismatch cycles.
- Event pulses are registered and coincide with the cycle in which `st` (and therefore `o_io_sw`) first shows the new value.
  - Key 0→1 raises `o_key_press`.
  - Key 1→0 raises `o_key_release`.
  - Any switch toggle raises `o_sw_change`.
- A pulse is high for exactly one cycle. The same channel cannot pulse again for at least DEBOUNCE_CYCLES cycles.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.
- The counter never exceeds DEBOUNCE_CYCLES-1 and has no wrap-around path.
- `o_io_sw[31:N_SW+N_KEY]` is constant 0.

## Timing
- Reset values: all `s1`, `s2`, `st` = 0 (switches off, keys released); all `cnt` = 0; `o_io_sw` = 0; all pulse outputs = 0.
- Reset asserted mid-count or mid-pulse clears every register immediately and asynchronously. Any pulse in flight is dropped.
- After reset release, a switch already ON is treated as a fresh change. It appears after the normal latency with an `o_sw_change` pulse.
- Latency: a raw level held stable first sampled at rising edge E0 appears on `o_io_sw`, with its pulse, after edge E0+DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 rising edges in total.
- A raw glitch shorter than DEBOUNCE_CYCLES cycles, as seen at `s2`, never reaches the outputs.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, N_SW=10, N_KEY=4.
1. Reset then idle with `i_key_n`=4'hF and `i_sw`=0 → `o_io_sw`=32'h0 and no pulses for 50 cycles. Then `i_reset`=0 asserted mid-cycle → all outputs 0 before the next edge.
2. `i_sw[0]` 0→1 held, first sampled at edge E0 → `o_io_sw[0]`=1 and `o_sw_change[0]`=1 after edge E0+5, exactly one cycle wide. `o_io_sw[0]` stays at 1.
3. `i_key_n[0]` pressed (1→0) with bounce 0,1,0,0,1 then held 0 → `o_io_sw[10]`=1 only 6 edges after the final stable 0 is sampled. One `o_key_press[0]` pulse, no release pulse.
4. Key 0 released after a debounced press → `o_io_sw[10]` returns to 0 and `o_key_release[0]` pulses once. A 3-cycle glitch to 0 afterwards produces no change.
5. `i_sw`=10'h3FF and `i_key_n`=4'h0 applied in the same cycle → `o_io_sw`=32'h0000_3FFF on a single cycle. `o_sw_change`=10'h3FF and `o_key_press`=4'hF on that same cycle.
6. Reset asserted when `cnt`=2 on switch 5 → after release, with `i_sw[5]` still 1, the full latency is restarted: the change appears 6 edges after reset release, not earlier.
